// File: rtl/l0_west_feeder_if.sv
// Bus between the west-edge feeder and its producer/array: write port, stream control, lane outputs, status.
interface l0_west_feeder_if #(
    parameter int bw    = 4,
    parameter int row   = 8,
    parameter int depth = 16
);
    localparam int nw = $clog2(depth) + 1;

    logic [row*bw-1:0] in;
    logic              wr;
    logic              start;
    logic              mode;
    logic [nw-1:0]     n;
    logic [row*bw-1:0] out;
    logic [2*row-1:0]  inst;
    logic              full;
    logic              idle;
    logic              done;
    logic              err;
    logic              ovf;

    modport master (
        output in, wr, start, mode, n,
        input  out, inst, full, idle, done, err, ovf
    );

    modport slave (
        input  in, wr, start, mode, n,
        output out, inst, full, idle, done, err, ovf
    );
endinterface

// File: rtl/l0_west_feeder.sv
// West-edge feeder: one FIFO per array row, streamed out as registered lane data plus instruction.
// Macro FEEDER_SKEW_EN: defined, lane r issues r cycles after lane 0; undefined, all lanes issue together.
module l0_west_feeder #(
    parameter int bw    = 4,
    parameter int row   = 8,
    parameter int depth = 16
) (
    input  logic            clk,
    input  logic            reset,
    l0_west_feeder_if.slave bus
);
    localparam int pw = $clog2(depth);
    localparam int nw = pw + 1;
    localparam int rw = $clog2(row) + 1;
    localparam int cw = (nw > rw) ? nw : rw;
`ifdef FEEDER_SKEW_EN
    localparam bit skew_en = 1'b1;
`else
    localparam bit skew_en = 1'b0;
`endif
    localparam int drain_cycles = skew_en ? row - 1 : 0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [cw-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [row-1:0]  vld_q;  // lane r presented a vector at the last edge
    logic [row-1:0]  pop;
    logic            pop0, start_ok, err_d, last_pop, push, full;
    logic            done_q, err_q, ovf_q;

    logic [bw-1:0]   mem    [row][depth];
    logic [pw-1:0]   rd_ptr [row];
    logic [pw-1:0]   wr_ptr [row];
    logic [nw-1:0]   count  [row];
    logic [bw-1:0]   data_q [row];

    always_comb begin
        full = 1'b0;
        for (int r = 0; r < row; r++)
            if (count[r] == nw'(depth)) full = 1'b1;
    end

    // A write is all-lanes-or-nothing, so every lane keeps the same vector sequence.
    assign push     = bus.wr & ~full;
    assign start_ok = (bus.n != '0) && (bus.n <= nw'(depth)) && (count[0] >= bus.n);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pop0    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_ok) begin
                        state_d = RUN;
                        cnt_d   = cw'(bus.n);
                        mode_d  = bus.mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    pop0  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else if (drain_cycles > 0) begin
                    state_d = DRAIN;
                    cnt_d   = cw'(drain_cycles - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Later lanes follow lane 0 through the valid register, which doubles as the skew shift register.
    always_comb begin
        pop    = '0;
        pop[0] = pop0;
        for (int r = 1; r < row; r++)
            pop[r] = skew_en ? vld_q[r-1] : pop0;
    end

    if (skew_en && row > 1) begin : g_last_skew
        assign last_pop = pop[row-1] & ~pop[row-2];
    end else begin : g_last_flat
        assign last_pop = pop0 & (cnt_q == cw'(1));
    end

    // NOTE: state registers use non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: the storage array is not reset; pointers and occupancy alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int r = 0; r < row; r++)
            if (push) mem[r][wr_ptr[r]] <= bus.in[r*bw +: bw];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++) begin
                rd_ptr[r] <= '0;
                wr_ptr[r] <= '0;
                count[r]  <= '0;
                data_q[r] <= '0;
            end
            vld_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            for (int r = 0; r < row; r++) begin
                if (push)   wr_ptr[r] <= wr_ptr[r] + 1'b1;
                if (pop[r]) rd_ptr[r] <= rd_ptr[r] + 1'b1;
                case ({push, pop[r]})
                    2'b10:   count[r] <= count[r] + 1'b1;
                    2'b01:   count[r] <= count[r] - 1'b1;
                    default: count[r] <= count[r];
                endcase
                data_q[r] <= pop[r] ? mem[r][rd_ptr[r]] : '0;
            end
            vld_q  <= pop;
            done_q <= last_pop;
            err_q  <= err_d;
            ovf_q  <= ovf_q | (bus.wr & full);
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_lane_out
        assign bus.out[r*bw +: bw] = data_q[r];
        assign bus.inst[2*r +: 2]  = vld_q[r] ? (mode_q ? 2'b10 : 2'b01) : 2'b00;
    end

    assign bus.full = full;
    assign bus.idle = (state_q == IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_l0_west_feeder.sv
// Scoreboard bench for l0_west_feeder: stimulus queues expected lane vectors, done and err pulses; a negedge monitor consumes them.
module tb_l0_west_feeder;
    localparam int bw    = 4;
    localparam int row   = 8;
    localparam int depth = 16;
    localparam int nw    = $clog2(depth) + 1;
`ifdef FEEDER_SKEW_EN
    localparam int sk = 1;
`else
    localparam int sk = 0;
`endif

    typedef struct {
        int            cyc;
        logic [bw-1:0] data;
        logic [1:0]    inst;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    int   idle_chk = -1;

    exp_t              lane_q [row][$];
    int                done_q [$];
    int                err_q  [$];
    logic [row*bw-1:0] fifo_m [$];

    logic [1:0]    mon_i;
    logic [bw-1:0] mon_d;
    exp_t          mon_e;

    l0_west_feeder_if #(.bw(bw), .row(row), .depth(depth)) bus ();

    l0_west_feeder #(.bw(bw), .row(row), .depth(depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [row*bw-1:0] mk(input int s);
        logic [row*bw-1:0] v;
        for (int r = 0; r < row; r++) v[r*bw +: bw] = bw'(s * 7 + r * 3 + 1);
        return v;
    endfunction

    // One cycle of stimulus; st_exp: 1 accepted, 0 rejected with err, 2 ignored silently.
    task automatic step(input bit st, input bit m, input int nn, input bit w,
                        input logic [row*bw-1:0] d, input int st_exp, input bit w_ok);
        @(negedge clk);
        #1;
        bus.start = st;
        bus.mode  = m;
        bus.n     = nw'(nn);
        bus.wr    = w;
        bus.in    = d;
        if (st) begin
            int k;
            k = cyc + 1;
            if (st_exp == 1) begin
                for (int i = 0; i < nn; i++) begin
                    logic [row*bw-1:0] v;
                    v = fifo_m.pop_front();
                    for (int r = 0; r < row; r++) begin
                        exp_t e;
                        e.cyc  = k + 1 + sk * r + i;
                        e.data = v[r*bw +: bw];
                        e.inst = m ? 2'b10 : 2'b01;
                        lane_q[r].push_back(e);
                    end
                end
                done_q.push_back(k + nn + sk * (row - 1));
            end else if (st_exp == 0) begin
                err_q.push_back(k);
            end
        end
        if (w && w_ok) fifo_m.push_back(d);
    endtask

    task automatic nop(input int c);
        repeat (c) step(1'b0, 1'b0, 0, 1'b0, '0, 2, 1'b0);
    endtask

    task automatic wr_vec(input int s);
        step(1'b0, 1'b0, 0, 1'b1, mk(s), 2, 1'b1);
    endtask

    task automatic start_s(input bit m, input int nn, input int ex);
        step(1'b1, m, nn, 1'b0, '0, ex, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.wr    = 1'b0;
        for (int r = 0; r < row; r++) lane_q[r].delete();
        done_q.delete();
        err_q.delete();
        fifo_m.delete();
        idle_chk = -1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " out"},  bus.out,  '0);
        check({tag, " inst"}, bus.inst, '0);
        check({tag, " full"}, bus.full, 1'b0);
        check({tag, " idle"}, bus.idle, 1'b1);
        check({tag, " done"}, bus.done, 1'b0);
        check({tag, " err"},  bus.err,  1'b0);
        check({tag, " ovf"},  bus.ovf,  1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int r = 0; r < row; r++) begin
                mon_i = bus.inst[2*r +: 2];
                mon_d = bus.out[r*bw +: bw];
                if (mon_i != 2'b00) begin
                    if (lane_q[r].size() == 0) begin
                        check($sformatf("unexpected valid lane %0d", r), mon_i, 2'b00);
                    end else begin
                        mon_e = lane_q[r].pop_front();
                        check($sformatf("lane %0d cycle", r), cyc, mon_e.cyc);
                        check($sformatf("lane %0d inst/data", r), {mon_i, mon_d}, {mon_e.inst, mon_e.data});
                    end
                end else if (mon_d != '0) begin
                    check($sformatf("lane %0d out while invalid", r), mon_d, '0);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected done", bus.done, 1'b0);
                end else begin
                    check("done cycle", cyc, done_q.pop_front());
                    check("idle with done", bus.idle, 1'b0);
                    idle_chk = cyc + 1;
                end
            end
            if (cyc == idle_chk) check("idle after done", bus.idle, 1'b1);
            if (bus.err) begin
                if (err_q.size() == 0) begin
                    check("unexpected err", bus.err, 1'b0);
                end else begin
                    check("err cycle", cyc, err_q.pop_front());
                    check("idle with err", bus.idle, 1'b1);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        bus.in    = '0;
        bus.wr    = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.n     = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        check_quiet("reset");

        // Execute stream of 4; a start during RUN is ignored without err.
        for (int i = 0; i < 4; i++) wr_vec(i);
        start_s(1'b1, 4, 1);
        start_s(1'b0, 1, 2);
        nop(20);

        // Rejected starts: too few entries, then n = 0; then drain the two entries.
        wr_vec(10);
        wr_vec(11);
        start_s(1'b1, 3, 0);
        start_s(1'b1, 0, 0);
        start_s(1'b0, 2, 1);
        nop(14);

        // Fill to depth, overflow attempt, n above depth, then full-depth read.
        for (int i = 0; i < depth; i++) wr_vec(20 + i);
        nop(1);
        check("full at depth", bus.full, 1'b1);
        check("no ovf yet", bus.ovf, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1, mk(99), 2, 1'b0);
        nop(1);
        check("ovf after blocked write", bus.ovf, 1'b1);
        check("still full", bus.full, 1'b1);
        start_s(1'b1, depth + 1, 0);
        start_s(1'b1, depth, 1);
        nop(30);
        check("full clears after read", bus.full, 1'b0);
        check("ovf sticky", bus.ovf, 1'b1);

        // Weight load while writing every cycle; occupancy afterwards equals the 7 writes.
        for (int i = 0; i < 8; i++) wr_vec(40 + i);
        start_s(1'b0, 8, 1);
        for (int i = 0; i < 7; i++) wr_vec(50 + i);
        nop(25);
        start_s(1'b1, 8, 0);
        start_s(1'b1, 7, 1);
        nop(25);

        // Reset three edges into a stream: outputs clear, no done, storage emptied.
        for (int i = 0; i < 8; i++) wr_vec(60 + i);
        start_s(1'b1, 8, 1);
        nop(2);
        do_reset();
        check_quiet("mid-stream reset");
        start_s(1'b1, 1, 0);
        nop(20);

        // Short stream of two.
        wr_vec(70);
        wr_vec(71);
        start_s(1'b1, 2, 1);
        nop(15);

        for (int r = 0; r < row; r++) check($sformatf("lane %0d leftover", r), lane_q[r].size(), 0);
        check("done leftover", done_q.size(), 0);
        check("err leftover", err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l0_west_feeder.md
L0_WEST_FEEDER -- requirements
Module: l0_west_feeder

Interface
REQ-001 Parameter bw, default 4: activation/weight word width in bits.
REQ-002 Parameter row, default 8: number of array rows fed, one lane per row.
REQ-003 Parameter depth, default 16: entries per lane FIFO, power of two.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  row*bw  write vector; lane r uses bits [r*bw+bw-1 : r*bw].
REQ-007 wr  input  1  pushes in into all lane FIFOs.
REQ-008 start  input  1  launches a stream when the block is idle.
REQ-009 mode  input  1  sampled with start: 0 = weight load, 1 = execute.
REQ-010 n  input  clog2(depth)+1  sampled with start: number of vectors to stream.
REQ-011 out  output  row*bw  lane data to the array west edge; lane r drives row r in_w.
REQ-012 inst  output  2*row  per-lane instruction; lane r bits [2r+1:2r] drive row r inst_w.
REQ-013 full  output  1  high when any lane FIFO holds depth entries.
REQ-014 idle  output  1  high in state IDLE.
REQ-015 done  output  1  one-cycle pulse when the last lane has issued its last vector.
REQ-016 err  output  1  one-cycle pulse when a start is rejected.
REQ-017 ovf  output  1  sticky overflow flag; cleared only by reset.

Function
REQ-018 States: IDLE, RUN, DRAIN; the state register is the only controller state besides the issue counter and the lane-enable shift register.
REQ-019 In IDLE, start is accepted only if 1 <= n <= depth and lane 0 holds at least n entries; otherwise start is ignored and err pulses in the next cycle.
REQ-020 On an accepted start sampled at edge k, mode and n are latched, state becomes RUN, and lane 0 pops one entry per cycle for n cycles.
REQ-021 Lane r (r >= 1) pops exactly r cycles after lane 0 for the same vector, through a 1-bit enable shift register, giving a diagonal skew.
REQ-022 out and inst are registered: lane r data is valid from edge k+1+r through edge k+r+n, on n consecutive cycles.
REQ-023 While lane r is valid, inst lane r = 2'b01 for mode 0 and 2'b10 for mode 1; otherwise inst lane r = 2'b00 and out lane r = 0.
REQ-024 After lane 0 issues its n-th pop, state moves to DRAIN for row-1 cycles, then to IDLE; done pulses in the cycle lane row-1 presents its last vector.
REQ-025 Each lane FIFO keeps its own read pointer, write pointer and occupancy, wrapping modulo depth.
REQ-026 wr with full high writes nothing to any lane and sets ovf; a partial write across lanes is never performed.
REQ-027 wr is legal in every state; a simultaneous push and pop on one lane leaves that lane's occupancy unchanged, and a lane holding depth-1 entries accepts the push.
REQ-028 start asserted in RUN or DRAIN is ignored without err.
REQ-029 Popping an empty lane cannot occur, because admission is checked against lane 0 and the later lanes never hold fewer entries than lane 0.

Reset
REQ-030 reset clears all FIFO pointers and occupancies, returns state to IDLE, and zeroes the shift register.
REQ-031 After reset: out = 0, inst = 0, full = 0, idle = 1, done = 0, err = 0, ovf = 0.
REQ-032 reset asserted mid-stream aborts the stream, discards the stored data, and produces no done pulse.

Configuration
REQ-033 Macro FEEDER_SKEW_EN defined: the skew of REQ-021 and REQ-024 applies.
REQ-034 Macro FEEDER_SKEW_EN undefined: all lanes pop together, and lane r is valid from k+1 through k+n.
REQ-035 Macro FEEDER_SKEW_EN undefined: DRAIN lasts 0 cycles, and done pulses with the last vector of all lanes.

Verification
REQ-036 Reset, then write 4 vectors, then start with mode=1 and n=4 at edge 10 -> lane 0 shows inst 10 at edges 11-14, and lane 7 shows the same data at edges 18-21.
REQ-037 Lane 7 case of REQ-036 -> done pulses at edge 21, and idle rises the cycle after.
REQ-038 With 2 entries stored, start with n=3; separately, start with n=0 -> err pulses once for each, and state stays IDLE.
REQ-039 Write 16 vectors, then pulse wr again -> full=1, ovf=1, and the stored contents are unchanged on a subsequent n=16 read.
REQ-040 Start with mode=0 and n=8 while wr pushes every cycle -> inst lanes show 01 with correct skew, and occupancy ends equal to the number of writes during the run.
REQ-041 Reset at edge k+3 of a mode=1, n=8 stream -> out and inst are 0 from the next edge, no done pulse occurs, and occupancy is 0.
REQ-042 Without FEEDER_SKEW_EN, n=2 -> all lanes are valid on the same 2 cycles, and done pulses on the second.
